// File: rtl/edge_sched_pkg.sv
// Shared encodings and constants for the edge event scheduler.
package edge_sched_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    DetZero = 2'b00,
    DetEdg  = 2'b01,
    DetOne  = 2'b10
  } det_state_e;

  typedef enum logic {
    SchedIdle  = 1'b0,
    SchedGrant = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rise_tick_fsm.sv
// Single-channel Moore rising-edge detector: tick_o is high for exactly one cycle per edge.
module rise_tick_fsm
  import edge_sched_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic tick_o
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= DetZero;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DetZero: if (level_i) state_d = DetEdg;
      DetEdg:  state_d = level_i ? DetOne : DetZero;
      DetOne:  if (!level_i) state_d = DetZero;
      default: state_d = DetZero;
    endcase
  end

  assign tick_o = (state_q == DetEdg);

endmodule

// File: rtl/edge_event_scheduler.sv
// Edge-to-event scheduler: per-channel edge detectors feed pending flags served round-robin
// over a req/ack grant. Define SCHED_DROP_COUNT_EN to build the saturating lost-event counter.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [N_CH-1:0]       level_i,
  input  logic                  ack_i,
  output logic                  grant_valid_o,
  output logic [N_CH-1:0]       grant_o,
  output logic [ID_W-1:0]       grant_id_o,
  output logic [N_CH-1:0]       pending_o,
  output logic [N_CH-1:0]       drop_o,
  output logic [DROP_CNT_W-1:0] drop_count_o
);

  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] drop_q, drop_d, drop_set;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [N_CH-1:0] clr;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  sched_state_e    state_q, state_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_det
    rise_tick_fsm u_det (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .level_i (level_i[g]),
      .tick_o  (tick[g])
    );
  end

  // Round-robin pick: lowest pending index above last_id, else lowest pending overall.
  logic [ID_W-1:0] hi_idx, lo_idx, sel_idx;
  logic            hi_found;
  logic [N_CH-1:0] sel_oh;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) > last_id_q) begin
          hi_idx   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
    sel_oh  = {{(N_CH-1){1'b0}}, 1'b1} << sel_idx;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    clr        = '0;
    case (state_q)
      SchedIdle: begin
        if (|pending_q) begin
          state_d    = SchedGrant;
          grant_d    = sel_oh;
          grant_id_d = sel_idx;
          last_id_d  = sel_idx;
          clr        = sel_oh;
        end
      end
      SchedGrant: begin
        if (ack_i) begin
          state_d    = SchedIdle;
          grant_d    = '0;
          grant_id_d = '0;
        end
      end
      default: begin
        state_d    = SchedIdle;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // A tick coinciding with the grant clear re-arms the flag rather than being lost.
  assign drop_set  = tick & pending_q & ~clr;
  assign pending_d = (pending_q & ~clr) | tick;
  assign drop_d    = drop_q | drop_set;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= SchedIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_CH - 1);
      pending_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

`ifdef SCHED_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < N_CH; i++) begin
      cnt_sum = cnt_sum + {{DROP_CNT_W{1'b0}}, drop_set[i]};
    end
    drop_cnt_d = cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

  assign grant_valid_o = (state_q == SchedGrant);
  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign pending_o     = pending_q;
  assign drop_o        = drop_q;

endmodule
